uart_tx_buffer: RTL

//   Byte FIFO and handshake sequencer directly upstream of the UART transmitter.

---
 rtl/uart_tx_buffer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer
//   Byte FIFO plus handshake sequencer sitting directly in front of the UART
//   transmitter. Bytes are queued at any rate. One byte at a time is presented
//   on para_data with a single-cycle uart_tx_enable strobe. The next byte is
//   released only after the transmitter has raised and then dropped tx_done.
//
// Ports
//   uart_clk        system clock
//   uart_rst_p      synchronous reset, active-high
//   wr_en/wr_data   byte write strobe and data
//   fifo_full       DEPTH entries stored
//   fifo_empty      no entries stored
//   fifo_count      entries stored, 0..DEPTH
//   wr_ovf          1-cycle pulse, a write was dropped because the FIFO was full
//   tx_done         frame-complete flag from the transmitter
//   uart_tx_enable  1-cycle start pulse to the transmitter
//   para_data       byte being transmitted, stable for the whole frame
//   tx_busy         high whenever the sequencer is not idle
//   tx_err          1-cycle pulse, watchdog abort of the current frame
//
// State table
//   state | meaning
//   IDLE  | waiting for a queued byte while tx_done is low
//   LOAD  | pop head of FIFO into para_data
//   START | uart_tx_enable high for this single cycle
//   BUSY  | frame in flight, waiting for tx_done (watchdog runs here)
//   DRAIN | waiting for tx_done to clear before the next frame
module uart_tx_buffer #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int TX_TIMEOUT = 0
) (
  input  logic              uart_clk,
  input  logic              uart_rst_p,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              wr_ovf,
  input  logic              tx_done,
  output logic              uart_tx_enable,
  output logic [7:0]        para_data,
  output logic              tx_busy,
  output logic              tx_err
);

  localparam int WD_W = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_BUSY,
    S_DRAIN
  } state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic [WD_W-1:0]   wd_cnt;
  logic              wr_accept;
  logic              pop;

  // Full is judged on the registered flag, so a write while full is dropped
  // even if a pop happens in the same cycle.
  assign wr_accept = wr_en && !fifo_full;
  // LOAD is only entered with a non-empty FIFO, so the pop is always valid.
  assign pop       = (state == S_LOAD);

  always_comb begin
    count_nxt = fifo_count;
    if (wr_accept && !pop)
      count_nxt = fifo_count + (ADDR_W+1)'(1);
    else if (!wr_accept && pop)
      count_nxt = fifo_count - (ADDR_W+1)'(1);
  end

  always_ff @(posedge uart_clk) begin
    if (!uart_rst_p && wr_accept)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge uart_clk) begin
    if (uart_rst_p) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      wr_ovf     <= 1'b0;
    end else begin
      if (wr_accept)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + ADDR_W'(1);
      fifo_count <= count_nxt;
      // DEPTH is a power of two, so the count MSB alone flags full.
      fifo_full  <= count_nxt[ADDR_W];
      fifo_empty <= (count_nxt == '0);
      wr_ovf     <= wr_en && fifo_full;
    end
  end

  always_ff @(posedge uart_clk) begin
    if (uart_rst_p) begin
      state          <= S_IDLE;
      uart_tx_enable <= 1'b0;
      para_data      <= 8'h00;
      tx_busy        <= 1'b0;
      tx_err         <= 1'b0;
      wd_cnt         <= '0;
    end else begin
      uart_tx_enable <= 1'b0;
      tx_err         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty && !tx_done) begin
            state   <= S_LOAD;
            tx_busy <= 1'b1;
          end
        end
        S_LOAD: begin
          para_data      <= mem[rd_ptr];
          uart_tx_enable <= 1'b1;
          state          <= S_START;
        end
        S_START: begin
          // Down-counter loaded on BUSY entry; terminal count 0 marks the
          // TX_TIMEOUT-th cycle spent in BUSY.
          wd_cnt <= WD_W'(TX_TIMEOUT - 1);
          state  <= S_BUSY;
        end
        S_BUSY: begin
          if (tx_done) begin
            state <= S_DRAIN;
          end else if (TX_TIMEOUT != 0 && wd_cnt == '0) begin
            state   <= S_IDLE;
            tx_busy <= 1'b0;
            tx_err  <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt - WD_W'(1);
          end
        end
        S_DRAIN: begin
          if (!tx_done) begin
            state   <= S_IDLE;
            tx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
